regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two write-back requesters: ALU result and memory-load return.
- Applies sub-word write masks for byte and halfword loads.
- Keeps a per-register pending-write scoreboard so decode can stall on RS/RT read-after-write hazards.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- CNT_W, 2, width of per-register pending-write counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rsv_valid  input  1  decode issues an instruction that will write rsv_addr
- rsv_addr  input  ADDR_W  destination register being reserved
- alu_valid  input  1  ALU write-back request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  ADDR_W  ALU destination
- alu_data  input  DATA_W  ALU result
- alu_size  input  2  00 word, 01 half, 10 byte, 11 illegal
- mem_valid  input  1  load write-back request
- mem_ready  output  1  load request accepted this cycle
- mem_addr  input  ADDR_W  load destination
- mem_data  input  DATA_W  load data
- mem_size  input  2  same encoding as alu_size
- rf_we  output  1  register file write enable
- rf_waddr  output  ADDR_W  write address
- rf_wdata  output  DATA_W  write data
- rf_wmask  output  4  byte-lane enables, bit0 = bits 7:0
- rs, rt  input  ADDR_W  decode read addresses
- hazard_rs, hazard_rt  output  1  pending write to rs / rt
- err  output  1  sticky: illegal size or scoreboard over/underflow

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, rf_wmask=0, err=0, all counters=0, last_grant=ALU (so MEM wins the first conflict).
- Handshake: xxx_ready is combinational and asserts in the cycle the request is granted. Transfer occurs when valid&&ready. Requesters hold valid/addr/data/size stable until accepted.
- Arbitration, round-robin:
  - At most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted, then last_grant is updated.
- Latency: the accepted transfer at rising edge N appears on rf_* during cycle N+1 (registered); rf_we is high for exactly one cycle per transfer.
- Mask: size 00 -> 1111, 01 -> 0011, 10 -> 0001. Size 11 is written as 1111 and sets err.
- rf_wdata carries the request data unmodified.
- Address 0:
  - Requests to address 0 are accepted (ready asserted) but rf_we stays 0 and no counter changes.
  - rsv_addr 0 is ignored.
- Scoreboard: one CNT_W counter per register.
  - rsv_valid increments cnt[rsv_addr].
  - An accepted write decrements cnt[addr].
  - Increment and decrement to the same register in one cycle: net unchanged.
  - Increment at max saturates and sets err; decrement at 0 stays 0 and sets err.
- Hazards: hazard_rs = (cnt[rs]!=0) && rs!=0, combinational; hazard_rt the same for rt. A write accepted at edge N clears the hazard from cycle N+1 onward, matching rf_we timing.
- Reset mid-operation: all state cleared immediately; any in-flight rf_we is dropped.

Optional Feature:
- WB_FIXED_PRIO_EN
  - Defined: MEM always wins conflicts; last_grant register removed.
  - Undefined: round-robin as above.

Test Plan:
- Reset, then alu_valid=1, addr=5, data=0xDEADBEEF, size=00 -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_wmask=1111.
- Both valid every cycle for 4 cycles, alu_addr=3, mem_addr=4 -> grants MEM, ALU, MEM, ALU. With WB_FIXED_PRIO_EN: MEM four times, alu_ready stays 0.
- rsv_valid addr=7, rs=7 -> hazard_rs=1 from next cycle. A second rsv to addr 7 gives cnt=2. Two mem writes to addr 7 -> hazard_rs=0 only after the second write's rf_we cycle.
- mem_size=10, addr=9, data=0x000000AB -> rf_wmask=0001. mem_size=11 -> rf_wmask=1111 and err=1, staying 1 until rst.
- alu write to addr 0 with rsv_addr 0 -> alu_ready=1, rf_we stays 0, hazard_rs with rs=0 stays 0.
- Assert rst while rf_we=1 and cnt[6]=1 -> rf_we=0 and hazard for reg 6 cleared asynchronously, before the next clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back arbiter with sub-word masks and pending-write scoreboard
// Optional: define WB_FIXED_PRIO_EN to make loads always win write-port conflicts.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [1:0]        alu_size,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        mem_size,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        rf_wmask,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              hazard_rs,
    output logic              hazard_rt,
    output logic              err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt     [NREG];
    logic [CNT_W-1:0]  cnt_nxt [NREG];
    logic [NREG-1:0]   inc_hit;
    logic [NREG-1:0]   dec_hit;
    logic              cnt_err;

    logic              grant_alu;
    logic              grant_mem;
    logic              granted;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        w_size;
    logic [3:0]        w_mask;

`ifdef WB_FIXED_PRIO_EN
    assign grant_mem = mem_valid;
    assign grant_alu = alu_valid && !mem_valid;
`else
    // last_mem = 1 when the most recent grant went to the load port.
    logic last_mem;

    assign grant_mem = mem_valid && (!alu_valid || !last_mem);
    assign grant_alu = alu_valid && (!mem_valid || last_mem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_mem <= 1'b0;
        end else if (grant_alu || grant_mem) begin
            last_mem <= grant_mem;
        end
    end
`endif

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign granted   = grant_alu || grant_mem;

    always_comb begin
        w_addr = grant_mem ? mem_addr : alu_addr;
        w_data = grant_mem ? mem_data : alu_data;
        w_size = grant_mem ? mem_size : alu_size;
        case (w_size)
            2'b01:   w_mask = 4'b0011;
            2'b10:   w_mask = 4'b0001;
            default: w_mask = 4'b1111;
        endcase
    end

    // Register 0 is hardwired, so it never reserves nor retires a write.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (rsv_valid && rsv_addr != '0) inc_hit[rsv_addr] = 1'b1;
        if (granted && w_addr != '0)     dec_hit[w_addr]   = 1'b1;
    end

    always_comb begin
        cnt_err = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt[i] = cnt[i];
            if (inc_hit[i] && !dec_hit[i]) begin
                if (cnt[i] == CNT_MAX) cnt_err = 1'b1;
                else                   cnt_nxt[i] = cnt[i] + 1'b1;
            end else if (dec_hit[i] && !inc_hit[i]) begin
                if (cnt[i] == '0) cnt_err = 1'b1;
                else              cnt_nxt[i] = cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_wmask <= 4'b0000;
            err      <= 1'b0;
        end else begin
            rf_we <= granted && (w_addr != '0);
            if (granted) begin
                rf_waddr <= w_addr;
                rf_wdata <= w_data;
                rf_wmask <= w_mask;
            end
            if ((granted && w_size == 2'b11) || cnt_err) err <= 1'b1;
        end
    end

    assign hazard_rs = (rs != '0) && (cnt[rs] != '0);
    assign hazard_rt = (rt != '0) && (cnt[rt] != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
// Honours WB_FIXED_PRIO_EN when the design is built with it.
module tb_regfile_wb_arbiter;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic [1:0]  alu_size;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_size;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_wmask;
    logic [4:0]  rs, rt;
    logic        hazard_rs, hazard_rt;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    int          m_cnt [32];
    bit          m_last_mem;
    bit          m_err;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    bit          p_ga, p_gm;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_data(alu_data), .alu_size(alu_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_size(mem_size),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wmask(rf_wmask),
        .rs(rs), .rt(rt), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_last_mem = 0;
        m_err      = 0;
        m_we       = 0;
        m_waddr    = 0;
        m_wdata    = 0;
        m_wmask    = 0;
    endtask

    task automatic predict();
        if (alu_valid && mem_valid) begin
`ifdef WB_FIXED_PRIO_EN
            p_gm = 1; p_ga = 0;
`else
            p_gm = !m_last_mem; p_ga = m_last_mem;
`endif
        end else begin
            p_ga = alu_valid; p_gm = mem_valid;
        end
    endtask

    task automatic model_update();
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  s;
        int          n;
        m_we = 0;
        a = p_gm ? mem_addr : alu_addr;
        d = p_gm ? mem_data : alu_data;
        s = p_gm ? mem_size : alu_size;
        if (p_ga || p_gm) begin
            m_last_mem = p_gm;
            if (s == 2'd3) m_err = 1;
            m_we    = (a != 0);
            m_waddr = a;
            m_wdata = d;
            m_wmask = (s == 2'd1) ? 4'b0011 : (s == 2'd2) ? 4'b0001 : 4'b1111;
        end
        for (int i = 1; i < 32; i++) begin
            n = m_cnt[i];
            if (rsv_valid && rsv_addr == i) n = n + 1;
            if ((p_ga || p_gm) && a == i) n = n - 1;
            if (n > CMAX) begin n = CMAX; m_err = 1; end
            if (n < 0)    begin n = 0;    m_err = 1; end
            m_cnt[i] = n;
        end
    endtask

    task automatic cycle();
        predict();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rsv_valid = 0; rsv_addr = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0; alu_size = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0; mem_size = 0;
        rs = 0; rt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        rs = 5; rt = 9;
        rst = 1;
        #3;
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rf_wmask !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_rf: we=%b addr=%0d data=%h mask=%b, want all zero", rf_we, rf_waddr, rf_wdata, rf_wmask);
        end
        n_checks++;
        if (err !== 1'b0 || hazard_rs !== 1'b0 || hazard_rt !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: err=%b hrs=%b hrt=%b, want 0 0 0", err, hazard_rs, hazard_rt);
        end
        do_reset();
    endtask

    task automatic test_basic_write();
        do_reset();
        alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; alu_size = 2'b00;
        #2;
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_ready: alu_ready=%b mem_ready=%b, want 1 0", alu_ready, mem_ready);
        end
        cycle();
        idle_inputs();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || rf_wmask !== 4'b1111) begin
            n_errors++;
            $display("FAIL basic_write: we=%b addr=%0d data=%h mask=%b, want 1 5 deadbeef 1111", rf_we, rf_waddr, rf_wdata, rf_wmask);
        end
        cycle();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_one_pulse: rf_we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_round_robin();
        bit exp_mem;
        do_reset();
        alu_valid = 1; alu_addr = 3; alu_data = 32'h33; alu_size = 0;
        mem_valid = 1; mem_addr = 4; mem_data = 32'h44; mem_size = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef WB_FIXED_PRIO_EN
            exp_mem = 1;
`else
            exp_mem = (k % 2 == 0);
`endif
            #2;
            n_checks++;
            if (mem_ready !== exp_mem || alu_ready !== !exp_mem) begin
                n_errors++;
                $display("FAIL rr_grant[%0d]: mem_ready=%b alu_ready=%b, want %b %b", k, mem_ready, alu_ready, exp_mem, !exp_mem);
            end
            cycle();
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== (exp_mem ? 5'd4 : 5'd3)) begin
                n_errors++;
                $display("FAIL rr_write[%0d]: we=%b addr=%0d, want 1 %0d", k, rf_we, rf_waddr, exp_mem ? 4 : 3);
            end
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        do_reset();
        rs = 7; rt = 7;
        rsv_valid = 1; rsv_addr = 7;
        #2;
        n_checks++;
        if (hazard_rs !== 1'b0) begin
            n_errors++;
            $display("FAIL hz_before_rsv: hazard_rs=%b, want 0", hazard_rs);
        end
        cycle();
        n_checks++;
        if (hazard_rs !== 1'b1 || hazard_rt !== 1'b1) begin
            n_errors++;
            $display("FAIL hz_after_rsv: hrs=%b hrt=%b, want 1 1", hazard_rs, hazard_rt);
        end
        cycle();
        rsv_valid = 0;
        mem_valid = 1; mem_addr = 7; mem_data = 32'h1111_0007; mem_size = 0;
        cycle();
        mem_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || hazard_rs !== 1'b1) begin
            n_errors++;
            $display("FAIL hz_first_write: we=%b hazard_rs=%b, want 1 1 (cnt still 1)", rf_we, hazard_rs);
        end
        #2;
        mem_valid = 1; mem_data = 32'h2222_0007;
        cycle();
        mem_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || hazard_rs !== 1'b0 || hazard_rt !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL hz_second_write: we=%b hrs=%b hrt=%b err=%b, want 1 0 0 0", rf_we, hazard_rs, hazard_rt, err);
        end
        idle_inputs();
    endtask

    task automatic test_sizes();
        do_reset();
        rsv_valid = 1; rsv_addr = 9;
        cycle();
        cycle();
        rsv_valid = 0;
        mem_valid = 1; mem_addr = 9; mem_data = 32'h0000_00AB; mem_size = 2'b10;
        cycle();
        mem_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_wmask !== 4'b0001 || rf_wdata !== 32'h0000_00AB || err !== 1'b0) begin
            n_errors++;
            $display("FAIL size_byte: we=%b mask=%b data=%h err=%b, want 1 0001 000000ab 0", rf_we, rf_wmask, rf_wdata, err);
        end
        mem_valid = 1; mem_size = 2'b11; mem_data = 32'h1234_5678;
        cycle();
        mem_valid = 0;
        n_checks++;
        if (rf_wmask !== 4'b1111 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL size_illegal: mask=%b err=%b, want 1111 1", rf_wmask, err);
        end
        for (int k = 0; k < 3; k++) cycle();
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        do_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_cleared: err=%b, want 0", err);
        end
    endtask

    task automatic test_addr0();
        do_reset();
        rsv_valid = 1; rsv_addr = 0; rs = 0;
        alu_valid = 1; alu_addr = 0; alu_data = 32'hCAFE_F00D; alu_size = 0;
        #2;
        n_checks++;
        if (alu_ready !== 1'b1 || hazard_rs !== 1'b0) begin
            n_errors++;
            $display("FAIL addr0_ready: alu_ready=%b hazard_rs=%b, want 1 0", alu_ready, hazard_rs);
        end
        cycle();
        idle_inputs();
        n_checks++;
        if (rf_we !== 1'b0 || hazard_rs !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL addr0_write: we=%b hazard_rs=%b err=%b, want 0 0 0", rf_we, hazard_rs, err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsv_valid = 1; rsv_addr = 6; rs = 6;
        cycle();
        cycle();
        rsv_valid = 0;
        mem_valid = 1; mem_addr = 6; mem_data = 32'h6666_6666; mem_size = 0;
        cycle();
        mem_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || hazard_rs !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_setup: we=%b hazard_rs=%b, want 1 1", rf_we, hazard_rs);
        end
        rst = 1;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || hazard_rs !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: we=%b hazard_rs=%b, want 0 0 before next edge", rf_we, hazard_rs);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        idle_inputs();
    endtask

    task automatic test_random();
        bit alu_hold, mem_hold;
        do_reset();
        alu_hold = 0; mem_hold = 0;
        for (int k = 0; k < 400; k++) begin
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_addr  = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
                alu_size  = 2'($urandom_range(0, 2));
            end
            if (!mem_hold) begin
                mem_valid = ($urandom_range(0, 1) == 1);
                mem_addr  = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
                mem_size  = 2'($urandom_range(0, 2));
            end
            rsv_valid = ($urandom_range(0, 2) != 0);
            rsv_addr  = 5'($urandom_range(0, 7));
            rs        = 5'($urandom_range(0, 7));
            rt        = 5'($urandom_range(0, 7));
            #2;
            predict();
            n_checks++;
            if (alu_ready !== p_ga || mem_ready !== p_gm) begin
                n_errors++;
                $display("FAIL rnd_ready[%0d]: alu=%b mem=%b, want %b %b", k, alu_ready, mem_ready, p_ga, p_gm);
            end
            n_checks++;
            if (hazard_rs !== (rs != 0 && m_cnt[rs] != 0) || hazard_rt !== (rt != 0 && m_cnt[rt] != 0)) begin
                n_errors++;
                $display("FAIL rnd_hazard[%0d]: hrs=%b hrt=%b, want cnt[%0d]=%0d cnt[%0d]=%0d", k, hazard_rs, hazard_rt, rs, m_cnt[rs], rt, m_cnt[rt]);
            end
            cycle();
            alu_hold = alu_valid && !p_ga;
            mem_hold = mem_valid && !p_gm;
            n_checks++;
            if (rf_we !== m_we || err !== m_err || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata || rf_wmask !== m_wmask))) begin
                n_errors++;
                $display("FAIL rnd_write[%0d]: we=%b addr=%0d data=%h mask=%b err=%b, want %b %0d %h %b %b", k, rf_we, rf_waddr, rf_wdata, rf_wmask, err, m_we, m_waddr, m_wdata, m_wmask, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_clear();
        #1;
        test_reset();
        test_basic_write();
        test_round_robin();
        test_hazard();
        test_sizes();
        test_addr0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
